// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default floor count, floor index width helper,
// call direction encoding and hall-call dispatch FSM states.
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 8;

  function automatic int floor_width(input int num_floors);
    return (num_floors < 2) ? 1 : $clog2(num_floors);
  endfunction

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/rr_slot_picker.sv
// Round-robin search: first eligible slot at or after the pointer, wrapping.
module rr_slot_picker
  import elevator_pkg::*;
#(
  parameter  int NUM_SLOTS = 2 * DEFAULT_NUM_FLOORS,
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] eligible,
  input  logic [SLOT_W-1:0]    ptr,
  output logic [SLOT_W-1:0]    slot,
  output logic                 found
);

  logic [SLOT_W-1:0] cand;

  // Scan from the farthest offset down so the nearest eligible slot wins.
  always_comb begin
    found = 1'b0;
    slot  = ptr;
    cand  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      cand = SLOT_W'((int'(ptr) + i) % NUM_SLOTS);
      if (eligible[cand]) begin
        found = 1'b1;
        slot  = cand;
      end
    end
  end

endmodule

// File: rtl/hall_call_registrar.sv
// Hall call registrar: latches hall button presses into per-direction pending
// calls, lights the panel, and offers calls to the dispatcher round-robin.
module hall_call_registrar
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  localparam int FLOOR_W    = floor_width(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_request,
  input  logic [NUM_FLOORS-1:0] hall_dir_up_ndown,
  output logic [NUM_FLOORS-1:0] hall_ack,
  output logic [NUM_FLOORS-1:0] call_up_pending,
  output logic [NUM_FLOORS-1:0] call_down_pending,
  output logic                  dispatch_valid,
  output logic [FLOOR_W-1:0]    dispatch_floor,
  output logic                  dispatch_dir_up,
  input  logic                  dispatch_ready,
  input  logic                  service_valid,
  input  logic [FLOOR_W-1:0]    service_floor,
  input  logic                  service_dir_up
);

  localparam int NUM_SLOTS = 2 * NUM_FLOORS;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  logic [NUM_FLOORS-1:0] req_p1, armed_p1, req_rise;
  logic [NUM_SLOTS-1:0]  pending, dispatched, eligible;
  logic [NUM_SLOTS-1:0]  set_slot, clr_slot, accept_mask;
  logic [SLOT_W-1:0]     ptr, offer_slot, pick_slot, ptr_nxt;
  logic                  pick_found, accept, withdraw;
  state_e                state, state_nxt;

  // A button held through reset stays disarmed until it has been seen low.
  assign req_rise = hall_request & ~req_p1 & armed_p1;

  always_comb begin
    set_slot = '0;
    clr_slot = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      set_slot[2*f+1] = req_rise[f] && (hall_dir_up_ndown[f] == DIR_UP)   && (f != NUM_FLOORS - 1);
      set_slot[2*f]   = req_rise[f] && (hall_dir_up_ndown[f] == DIR_DOWN) && (f != 0);
    end
    if (service_valid && (int'(service_floor) < NUM_FLOORS))
      clr_slot[{service_floor, service_dir_up}] = 1'b1;
  end

  assign eligible    = pending & ~dispatched;
  assign accept      = (state == ST_OFFER) && dispatch_ready;
  assign withdraw    = (state == ST_OFFER) && clr_slot[offer_slot];
  assign accept_mask = accept ? (NUM_SLOTS'(1) << offer_slot) : '0;
  assign ptr_nxt     = (offer_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : offer_slot + SLOT_W'(1);

  rr_slot_picker #(.NUM_SLOTS(NUM_SLOTS)) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .slot     (pick_slot),
    .found    (pick_found)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_found) state_nxt = ST_OFFER;
      ST_OFFER: if (accept || withdraw) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Service clears take priority over same-cycle requests and acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_p1     <= '0;
      armed_p1   <= ~hall_request;
      pending    <= '0;
      dispatched <= '0;
      ptr        <= '0;
      offer_slot <= '0;
    end else begin
      state      <= state_nxt;
      req_p1     <= hall_request;
      armed_p1   <= armed_p1 | ~hall_request;
      pending    <= (pending | set_slot) & ~clr_slot;
      dispatched <= (dispatched | accept_mask) & ~clr_slot;
      if ((state == ST_IDLE) && pick_found)
        offer_slot <= pick_slot;
      if (accept)
        ptr <= ptr_nxt;
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FLOORS; f++) begin
      call_up_pending[f]   = pending[2*f+1];
      call_down_pending[f] = pending[2*f];
    end
  end

  assign hall_ack        = call_up_pending | call_down_pending;
  assign dispatch_valid  = (state == ST_OFFER);
  assign dispatch_floor  = offer_slot[SLOT_W-1:1];
  assign dispatch_dir_up = offer_slot[0];

endmodule
